// File: rtl/spot_centroid.sv
// spot_centroid: centroid of above-threshold pixels over one video frame
// Inputs : clk, rst (async, active-high), vsync (high = blanking), hsync (high = active line),
//          pix_en (pixel qualifier), pix (luminance), thresh (brightness threshold, latched at frame start)
// Outputs: spot_valid (one-cycle result strobe), spot_found, spot_x, spot_y, spot_cnt (held between strobes),
//          frame_drop (one-cycle pulse when a frame start arrives while the divider is busy)
module spot_centroid #(
    parameter int MAX_W   = 640,
    parameter int MAX_H   = 480,
    parameter int MIN_PIX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vsync,
    input  logic        hsync,
    input  logic        pix_en,
    input  logic [7:0]  pix,
    input  logic [7:0]  thresh,
    output logic        spot_valid,
    output logic        spot_found,
    output logic [9:0]  spot_x,
    output logic [8:0]  spot_y,
    output logic [18:0] spot_cnt,
    output logic        frame_drop
);
    localparam logic [9:0]  W_LIM = 10'(MAX_W);
    localparam logic [8:0]  H_LIM = 9'(MAX_H);
    localparam logic [18:0] MIN_C = 19'(MIN_PIX);

    typedef enum logic [2:0] {IDLE, ACCUM, DIV_X, DIV_Y, DONE} state_t;

    state_t      state_q, state_d;
    logic        vs_q, hs_q;
    logic [7:0]  thr_q, thr_d;
    logic [9:0]  col_q, col_d, col_eff, qx_q, qx_d;
    logic [8:0]  row_q, row_d;
    logic [27:0] sum_x_q, sum_x_d, sum_y_q, sum_y_d, dq_q, dq_d, dq_n;
    logic [18:0] cnt_q, cnt_d, rem_q, rem_d, rem_n;
    logic [19:0] rem_sh;
    logic [4:0]  it_q, it_d;
    logic        spot_valid_q, spot_valid_d, spot_found_q, spot_found_d, frame_drop_q, frame_drop_d;
    logic [9:0]  spot_x_q, spot_x_d;
    logic [8:0]  spot_y_q, spot_y_d;
    logic [18:0] spot_cnt_q, spot_cnt_d;
    logic        vs_rise, vs_fall, hs_rise, hs_fall, acc, bright, ge;

    assign spot_valid = spot_valid_q;
    assign spot_found = spot_found_q;
    assign spot_x     = spot_x_q;
    assign spot_y     = spot_y_q;
    assign spot_cnt   = spot_cnt_q;
    assign frame_drop = frame_drop_q;

    always_comb begin
        vs_rise = vsync & ~vs_q;
        vs_fall = ~vsync & vs_q;
        hs_rise = hsync & ~hs_q;
        hs_fall = ~hsync & hs_q;
        // a pixel arriving with the line-start edge is column 0
        col_eff = hs_rise ? '0 : col_q;
        acc     = hsync & pix_en;
        bright  = acc && col_eff < W_LIM && row_q < H_LIM && pix >= thr_q;
        // one restoring-division step: dq shifts dividend bits out and quotient bits in
        rem_sh  = {rem_q, dq_q[27]};
        ge      = rem_sh >= {1'b0, cnt_q};
        rem_n   = ge ? 19'(rem_sh - {1'b0, cnt_q}) : rem_sh[18:0];
        dq_n    = {dq_q[26:0], ge};
        state_d      = state_q;
        thr_d        = thr_q;
        col_d        = col_q;
        row_d        = row_q;
        sum_x_d      = sum_x_q;
        sum_y_d      = sum_y_q;
        cnt_d        = cnt_q;
        dq_d         = dq_q;
        rem_d        = rem_q;
        it_d         = it_q;
        qx_d         = qx_q;
        spot_valid_d = 1'b0;
        spot_found_d = spot_found_q;
        spot_x_d     = spot_x_q;
        spot_y_d     = spot_y_q;
        spot_cnt_d   = spot_cnt_q;
        frame_drop_d = vs_fall && state_q inside {DIV_X, DIV_Y, DONE};
        if (vs_fall && state_q inside {IDLE, ACCUM}) begin
            state_d = ACCUM;
            thr_d   = thresh;
            col_d   = '0;
            row_d   = '0;
            sum_x_d = '0;
            sum_y_d = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (vs_rise) begin
                        state_d = cnt_q >= MIN_C ? DIV_X : DONE;
                        dq_d    = sum_x_q;
                        rem_d   = '0;
                        it_d    = '0;
                    end else begin
                        col_d = col_eff;
                        if (hs_fall && row_q < H_LIM) row_d = row_q + 1'b1;
                        if (acc && col_eff < W_LIM) col_d = col_eff + 1'b1;
                        if (bright) begin
                            sum_x_d = sum_x_q + {18'd0, col_eff};
                            sum_y_d = sum_y_q + {19'd0, row_q};
                            cnt_d   = cnt_q + 1'b1;
                        end
                    end
                end
                DIV_X, DIV_Y: begin
                    dq_d  = dq_n;
                    rem_d = rem_n;
                    it_d  = it_q + 1'b1;
                    if (it_q == 5'd27) begin
                        it_d = '0;
                        if (state_q == DIV_X) begin
                            qx_d    = dq_n[9:0];
                            dq_d    = sum_y_q;
                            rem_d   = '0;
                            state_d = DIV_Y;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    state_d      = IDLE;
                    spot_valid_d = 1'b1;
                    spot_found_d = cnt_q >= MIN_C;
                    spot_x_d     = spot_found_d ? qx_q : '0;
                    spot_y_d     = spot_found_d ? dq_q[8:0] : '0;
                    spot_cnt_d   = cnt_q;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            vs_q         <= 1'b0;
            hs_q         <= 1'b0;
            thr_q        <= '0;
            col_q        <= '0;
            row_q        <= '0;
            sum_x_q      <= '0;
            sum_y_q      <= '0;
            cnt_q        <= '0;
            dq_q         <= '0;
            rem_q        <= '0;
            it_q         <= '0;
            qx_q         <= '0;
            spot_valid_q <= 1'b0;
            spot_found_q <= 1'b0;
            spot_x_q     <= '0;
            spot_y_q     <= '0;
            spot_cnt_q   <= '0;
            frame_drop_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            vs_q         <= vsync;
            hs_q         <= hsync;
            thr_q        <= thr_d;
            col_q        <= col_d;
            row_q        <= row_d;
            sum_x_q      <= sum_x_d;
            sum_y_q      <= sum_y_d;
            cnt_q        <= cnt_d;
            dq_q         <= dq_d;
            rem_q        <= rem_d;
            it_q         <= it_d;
            qx_q         <= qx_d;
            spot_valid_q <= spot_valid_d;
            spot_found_q <= spot_found_d;
            spot_x_q     <= spot_x_d;
            spot_y_q     <= spot_y_d;
            spot_cnt_q   <= spot_cnt_d;
            frame_drop_q <= frame_drop_d;
        end
    end
endmodule

// File: tb/tb_spot_centroid.sv
// tb_spot_centroid: directed frames against a pixel-stream centroid model, checked every cycle
module tb_spot_centroid;
    logic        clk = 1'b0;
    logic        rst, vsync, hsync, pix_en;
    logic [7:0]  pix, thresh;
    logic        spot_valid, spot_found, frame_drop;
    logic [9:0]  spot_x;
    logic [8:0]  spot_y;
    logic [18:0] spot_cnt;

    spot_centroid dut (
        .clk(clk), .rst(rst), .vsync(vsync), .hsync(hsync), .pix_en(pix_en),
        .pix(pix), .thresh(thresh), .spot_valid(spot_valid), .spot_found(spot_found),
        .spot_x(spot_x), .spot_y(spot_y), .spot_cnt(spot_cnt), .frame_drop(frame_drop)
    );

    always #5 clk = ~clk;

    // cycle n is the clock period that ends at rising edge n; a negedge sample after edge n lies in cycle n+1
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, failures = 0;
    int e_edge = 0, exp_vcyc = -1, exp_dcyc = -1, last_vobs = -1, obs;
    int m_cnt, m_sx, m_sy;
    int p_found = 0, p_x = 0, p_y = 0, p_cnt = 0;
    int h_found = 0, h_x = 0, h_y = 0, h_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic frame_start(input logic [7:0] th);
        thresh = th;
        vsync  = 1'b0;
        m_cnt  = 0;
        m_sx   = 0;
        m_sy   = 0;
        tick(1);
    endtask

    // rectangle [x0..x1] x [y0..y1] carries value v, everything else is 0
    task automatic drive_lines(input int nl, input int len, input int x0, input int x1,
                               input int y0, input int y1, input logic [7:0] v);
        for (int r = 0; r < nl; r++) begin
            for (int c = 0; c < len; c++) begin
                hsync  = 1'b1;
                pix_en = 1'b1;
                pix    = (c >= x0 && c <= x1 && r >= y0 && r <= y1) ? v : 8'd0;
                if (c < 640 && r < 480 && pix >= thresh) begin
                    m_cnt++;
                    m_sx += c;
                    m_sy += r;
                end
                tick(1);
            end
            hsync  = 1'b0;
            pix_en = 1'b0;
            pix    = 8'd0;
            tick(2);
        end
    endtask

    task automatic frame_end(input bit expect_result);
        vsync = 1'b1;
        if (expect_result) begin
            e_edge   = cyc + 1;
            p_found  = (m_cnt >= 4) ? 1 : 0;
            p_x      = p_found ? m_sx / m_cnt : 0;
            p_y      = p_found ? m_sy / m_cnt : 0;
            p_cnt    = m_cnt;
            exp_vcyc = e_edge + (p_found ? 58 : 2);
        end
        tick(1);
    endtask

    task automatic check_lit(input int cnt, input int x, input int y, input int found, input int lat);
        chk("model_cnt", p_cnt, cnt);
        chk("model_x", p_x, x);
        chk("model_y", p_y, y);
        chk("lit_cnt", spot_cnt, cnt);
        chk("lit_x", spot_x, x);
        chk("lit_y", spot_y, y);
        chk("lit_found", spot_found, found);
        chk("latency", last_vobs - e_edge, lat);
    endtask

    always @(negedge clk) begin
        obs = cyc + 1;
        if (obs == exp_vcyc) begin
            h_found   = p_found;
            h_x       = p_x;
            h_y       = p_y;
            h_cnt     = p_cnt;
            last_vobs = obs;
        end
        chk("spot_valid", spot_valid, obs == exp_vcyc);
        chk("frame_drop", frame_drop, obs == exp_dcyc);
        chk("spot_found", spot_found, h_found);
        chk("spot_x", spot_x, h_x);
        chk("spot_y", spot_y, h_y);
        chk("spot_cnt", spot_cnt, h_cnt);
    end

    initial begin
        rst = 1'b1; vsync = 1'b1; hsync = 1'b0; pix_en = 1'b0; pix = 8'd0; thresh = 8'd200;
        tick(3);
        chk("rst_valid", spot_valid, 0);
        chk("rst_cnt", spot_cnt, 0);
        chk("rst_drop", frame_drop, 0);
        rst = 1'b0;
        tick(2);
        // 3x3 bright block
        frame_start(8'd200); drive_lines(53, 110, 100, 102, 50, 52, 8'd255); frame_end(1); tick(62);
        check_lit(9, 101, 51, 1, 58);
        // too few pixels: short path
        frame_start(8'd200); drive_lines(5, 20, 5, 6, 3, 3, 8'd255); frame_end(1); tick(6);
        check_lit(2, 0, 0, 0, 2);
        // pixel equal to threshold counts
        frame_start(8'd200); drive_lines(24, 16, 10, 10, 20, 23, 8'd200); frame_end(1); tick(62);
        check_lit(4, 10, 21, 1, 58);
        // one below threshold never counts
        frame_start(8'd200); drive_lines(4, 16, 0, 15, 0, 3, 8'd199); frame_end(1); tick(6);
        check_lit(0, 0, 0, 0, 2);
        // overlong line clipped at 640 columns
        frame_start(8'd200); drive_lines(1, 700, 0, 699, 0, 0, 8'd255); frame_end(1); tick(62);
        check_lit(640, 319, 0, 1, 58);
        // frame start 10 cycles into the divide: dropped, previous result still delivered
        frame_start(8'd200); drive_lines(53, 110, 100, 102, 50, 52, 8'd255); frame_end(1); tick(9);
        vsync = 1'b0;
        exp_dcyc = cyc + 2;
        tick(1);
        drive_lines(10, 110, 0, 109, 0, 9, 8'd255);
        frame_end(0); tick(5);
        check_lit(9, 101, 51, 1, 58);
        frame_start(8'd200); drive_lines(24, 16, 10, 10, 20, 23, 8'd200); frame_end(1); tick(62);
        check_lit(4, 10, 21, 1, 58);
        // reset in the middle of accumulation
        frame_start(8'd200); drive_lines(10, 110, 100, 102, 5, 7, 8'd255);
        rst = 1'b1;
        h_found = 0; h_x = 0; h_y = 0; h_cnt = 0;
        exp_vcyc = -1; exp_dcyc = -1;
        tick(1);
        chk("mid_rst_found", spot_found, 0);
        chk("mid_rst_x", spot_x, 0);
        chk("mid_rst_y", spot_y, 0);
        chk("mid_rst_cnt", spot_cnt, 0);
        tick(1);
        rst = 1'b0;
        tick(2);
        frame_end(0); tick(3);
        frame_start(8'd200); drive_lines(53, 110, 100, 102, 50, 52, 8'd255); frame_end(1); tick(62);
        check_lit(9, 101, 51, 1, 58);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
